// File: rtl/tile_pkg.sv
// Shared constants for the LED tile renderer: texture select codes, RGB565 field
// positions and the default transparent key colour.
package tile_pkg;

   typedef enum logic [1:0] {
      SEL_TEX0 = 2'd0,
      SEL_TEX1 = 2'd1,
      SEL_ON   = 2'd2,
      SEL_OFF  = 2'd3
   } tex_sel_e;

   localparam int R_HI = 15;
   localparam int R_LO = 11;
   localparam int G_HI = 10;
   localparam int G_LO = 5;
   localparam int B_HI = 4;
   localparam int B_LO = 0;

   localparam logic [15:0] KEY_COLOR_DEF = 16'h0000;

endpackage

// File: rtl/pipe_delay.sv
// WIDTH x DEPTH shift register with synchronous clear; output lags input by DEPTH
// clocks, no stall path.
module pipe_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
)(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_stage [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else begin
         r_stage[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/led_tile_renderer.sv
// Per-cell texture selector (LED on/off, default, alternate) with key replacement.
// Latency ROM_LAT+1 clocks, one pixel per clock, no backpressure.
module led_tile_renderer
   import tile_pkg::*;
#(
   parameter int          COORD_W      = 9,
   parameter int          CELL_BITS    = 5,
   parameter int          N_LEDS       = 13,
   parameter int          LED_ROW      = 3,
   parameter int          LED_COL0     = 1,
   parameter int          ALT_LO       = 2,
   parameter int          ALT_HI       = 4,
   parameter int          ROM_LAT      = 1,
   parameter int          BLINK_FRAMES = 30,
   parameter logic [15:0] KEY_COLOR    = KEY_COLOR_DEF
)(
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [COORD_W-1:0]     i_x,
   input  logic [COORD_W-1:0]     i_y,
   input  logic                   i_de,
   input  logic                   i_frame,
   input  logic [N_LEDS-1:0]      i_status,
   input  logic [N_LEDS-1:0]      i_blink,
   output logic [2*CELL_BITS-1:0] o_rom_addr,
   input  logic [15:0]            i_tex_on,
   input  logic [15:0]            i_tex_off,
   input  logic [15:0]            i_tex0,
   input  logic [15:0]            i_tex1,
   output logic [4:0]             o_r,
   output logic [5:0]             o_g,
   output logic [4:0]             o_b,
   output logic                   o_de
);

   localparam int CELL_W = COORD_W - CELL_BITS;
   localparam int FC_W   = $clog2(BLINK_FRAMES + 1);

   localparam logic [CELL_W-1:0] LED_ROW_C  = CELL_W'(LED_ROW);
   localparam logic [CELL_W-1:0] LED_FIRST  = CELL_W'(LED_COL0);
   localparam logic [CELL_W-1:0] LED_LAST   = CELL_W'(LED_COL0 + N_LEDS - 1);
   localparam logic [CELL_W-1:0] ALT_LO_C   = CELL_W'(ALT_LO);
   localparam logic [CELL_W-1:0] ALT_HI_C   = CELL_W'(ALT_HI);
   localparam logic [FC_W-1:0]   FC_LAST    = FC_W'(BLINK_FRAMES - 1);

   logic [N_LEDS-1:0] r_status;
   logic [N_LEDS-1:0] r_blink;
   logic [FC_W-1:0]   r_frame_cnt;
   logic              r_phase;

   logic [CELL_W-1:0] w_cx, w_cy, w_off;
   logic [N_LEDS-1:0] w_led_eff, w_led_rev, w_led_shift;
   logic              w_led_cell;
   tex_sel_e          w_sel;
   logic [2:0]        w_dly;
   logic [15:0]       w_word, w_pix;

   logic [4:0] r_r;
   logic [5:0] r_g;
   logic [4:0] r_b;
   logic       r_de;

   assign o_rom_addr = {i_y[CELL_BITS-1:0], i_x[CELL_BITS-1:0]};

   // LED state is frozen at vertical blank so a frame never shows a half-updated row.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_status    <= '0;
         r_blink     <= '0;
         r_frame_cnt <= '0;
         r_phase     <= 1'b0;
      end else if (i_frame) begin
         r_status <= i_status;
         r_blink  <= i_blink;
         if (r_frame_cnt == FC_LAST) begin
            r_frame_cnt <= '0;
            r_phase     <= ~r_phase;
         end else begin
            r_frame_cnt <= r_frame_cnt + FC_W'(1);
         end
      end
   end

   assign w_cx      = i_x[COORD_W-1:CELL_BITS];
   assign w_cy      = i_y[COORD_W-1:CELL_BITS];
   assign w_off     = w_cx - LED_FIRST;
   assign w_led_eff = r_status & ~(r_blink & {N_LEDS{r_phase}});

   // Leftmost LED cell maps to the MSB, so reverse before indexing by column offset.
   always_comb begin
      w_led_rev = '0;
      for (int i = 0; i < N_LEDS; i++) w_led_rev[i] = w_led_eff[N_LEDS-1-i];
   end

   assign w_led_shift = w_led_rev >> w_off;
   assign w_led_cell  = (w_cy == LED_ROW_C) && (w_cx >= LED_FIRST) && (w_cx <= LED_LAST);

   always_comb begin
      w_sel = SEL_TEX0;
      if (w_led_cell)
         w_sel = w_led_shift[0] ? SEL_ON : SEL_OFF;
      else if ((w_cy < ALT_LO_C) || (w_cy > ALT_HI_C))
         w_sel = SEL_TEX1;
   end

   pipe_delay #(
      .WIDTH (3),
      .DEPTH (ROM_LAT)
   ) u_sel_dly (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   ({w_sel, i_de}),
      .o_q   (w_dly)
   );

   always_comb begin
      w_word = i_tex0;
      case (w_dly[2:1])
         SEL_TEX1: w_word = i_tex1;
         SEL_ON:   w_word = i_tex_on;
         SEL_OFF:  w_word = i_tex_off;
         default:  w_word = i_tex0;
      endcase
      w_pix = (w_word == KEY_COLOR) ? i_tex0 : w_word;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_r  <= '0;
         r_g  <= '0;
         r_b  <= '0;
         r_de <= 1'b0;
      end else begin
         r_de <= w_dly[0];
         r_r  <= w_dly[0] ? w_pix[R_HI:R_LO] : 5'd0;
         r_g  <= w_dly[0] ? w_pix[G_HI:G_LO] : 6'd0;
         r_b  <= w_dly[0] ? w_pix[B_HI:B_LO] : 5'd0;
      end
   end

   assign o_r  = r_r;
   assign o_g  = r_g;
   assign o_b  = r_b;
   assign o_de = r_de;

endmodule

// File: tb/tb_led_tile_renderer.sv
// Random pixel/frame stimulus into two renderer configurations, compared against a
// per-pixel reference model of cell mapping, LED latching, blinking and key replacement.
module tb_led_tile_renderer;

   localparam int NCYC = 4000;
   localparam int LA   = 1;
   localparam int LB   = 3;
   localparam int CBA  = 5;
   localparam int CBB  = 4;
   localparam int BFA  = 2;
   localparam int BFB  = 3;
   localparam logic [15:0] KA = 16'h0000;
   localparam logic [15:0] KB = 16'hFFFF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, de, frame;
   logic [8:0]  x, y;
   logic [12:0] status, blink;
   logic [15:0] a_on, a_off, a_t0, a_t1;
   logic [15:0] b_on, b_off, b_t0, b_t1;
   logic [9:0]  a_addr;
   logic [7:0]  b_addr;
   logic [4:0]  a_r, a_b, b_r, b_b;
   logic [5:0]  a_g, b_g;
   logic        a_de, b_de;

   led_tile_renderer #(
      .CELL_BITS(CBA), .ROM_LAT(LA), .BLINK_FRAMES(BFA), .KEY_COLOR(KA)
   ) dut_a (
      .i_clk(clk), .i_rst(rst), .i_x(x), .i_y(y), .i_de(de), .i_frame(frame),
      .i_status(status), .i_blink(blink), .o_rom_addr(a_addr),
      .i_tex_on(a_on), .i_tex_off(a_off), .i_tex0(a_t0), .i_tex1(a_t1),
      .o_r(a_r), .o_g(a_g), .o_b(a_b), .o_de(a_de)
   );

   led_tile_renderer #(
      .CELL_BITS(CBB), .ROM_LAT(LB), .BLINK_FRAMES(BFB), .KEY_COLOR(KB)
   ) dut_b (
      .i_clk(clk), .i_rst(rst), .i_x(x), .i_y(y), .i_de(de), .i_frame(frame),
      .i_status(status), .i_blink(blink), .o_rom_addr(b_addr),
      .i_tex_on(b_on), .i_tex_off(b_off), .i_tex0(b_t0), .i_tex1(b_t1),
      .o_r(b_r), .o_g(b_g), .o_b(b_b), .o_de(b_de)
   );

   logic [15:0] wa [NCYC][4];
   logic [15:0] wb [NCYC][4];
   logic [16:0] ea [NCYC];
   logic [16:0] eb [NCYC];
   bit          rh [NCYC];

   int          n_total = 0;
   int          n_bad   = 0;
   logic [12:0] m_status, m_blink;
   int          m_frames;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] rand_word();
      case ($urandom_range(0, 3))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   // What a pixel should look like, given the frame-latched LED state at entry time.
   function automatic logic [16:0] ref_pix(input int cb, input logic [15:0] key, input int bf,
                                           input logic [8:0] px, input logic [8:0] py,
                                           input logic pde, input logic [15:0] on,
                                           input logic [15:0] off, input logic [15:0] t0,
                                           input logic [15:0] t1);
      int cx, cy, k, phase;
      logic [15:0] word;
      cx    = int'(px) >> cb;
      cy    = int'(py) >> cb;
      phase = (m_frames / bf) % 2;
      if (cy == 3 && cx >= 1 && cx <= 13) begin
         k    = 12 - (cx - 1);
         word = (m_status[k] && !(m_blink[k] && phase == 1)) ? on : off;
      end else if (cy < 2 || cy > 4) begin
         word = t1;
      end else begin
         word = t0;
      end
      if (word == key) word = t0;
      return pde ? {1'b1, word} : 17'd0;
   endfunction

   // Output after edge m shows the pixel from lat+1 cycles earlier unless reset intervened.
   function automatic logic [16:0] exp_out(input int m, input int lat, input bit is_a);
      for (int j = m - 1 - lat; j <= m - 1; j++)
         if (j < 0 || rh[j]) return 17'd0;
      return is_a ? ea[m-1-lat] : eb[m-1-lat];
   endfunction

   initial begin
      int mode;
      rst = 1'b1; de = 1'b0; frame = 1'b0; x = '0; y = '0; status = '0; blink = '0;
      a_on = '0; a_off = '0; a_t0 = '0; a_t1 = '0;
      b_on = '0; b_off = '0; b_t0 = '0; b_t1 = '0;
      m_status = '0; m_blink = '0; m_frames = 0;

      for (int c = 0; c < NCYC; c++) begin
         @(negedge clk);
         rst    = (c < 4) || (c >= 2000 && c < 2002);
         frame  = (c == 2001) ? 1'b1 : ($urandom_range(0, 15) == 0);
         status = 13'($urandom);
         blink  = 13'($urandom);
         mode   = int'($urandom_range(0, 2));
         x      = 9'($urandom_range(0, 511));
         if (mode == 0)      y = 9'(96 + $urandom_range(0, 31));
         else if (mode == 1) y = 9'(48 + $urandom_range(0, 15));
         else                y = 9'($urandom_range(0, 511));
         de = ($urandom_range(0, 7) != 0);
         if (c == 4) begin
            x = '0; y = '0; de = 1'b1;
         end
         for (int k = 0; k < 4; k++) begin
            wa[c][k] = rand_word();
            wb[c][k] = rand_word();
         end
         if (c == 4) wa[c][3] = 16'hF800;

         if (c >= LA) begin
            a_on = wa[c-LA][0]; a_off = wa[c-LA][1]; a_t0 = wa[c-LA][2]; a_t1 = wa[c-LA][3];
         end
         if (c >= LB) begin
            b_on = wb[c-LB][0]; b_off = wb[c-LB][1]; b_t0 = wb[c-LB][2]; b_t1 = wb[c-LB][3];
         end

         rh[c] = rst;
         ea[c] = ref_pix(CBA, KA, BFA, x, y, de, wa[c][0], wa[c][1], wa[c][2], wa[c][3]);
         eb[c] = ref_pix(CBB, KB, BFB, x, y, de, wb[c][0], wb[c][1], wb[c][2], wb[c][3]);

         if (rst) begin
            m_status = '0; m_blink = '0; m_frames = 0;
         end else if (frame) begin
            m_status = status; m_blink = blink; m_frames++;
         end

         #1;
         chk("addr_a", 32'({y[4:0], x[4:0]}), 32'(a_addr));
         chk("addr_b", 32'(b_addr), 32'({y[3:0], x[3:0]}));

         @(posedge clk);
         #1;
         chk("pix_a", 32'({a_de, a_r, a_g, a_b}), 32'(exp_out(c + 1, LA, 1'b1)));
         chk("pix_b", 32'({b_de, b_r, b_g, b_b}), 32'(exp_out(c + 1, LB, 1'b0)));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/led_tile_renderer.md
# led_tile_renderer

Parametrised successor to the fixed 32x32 LED sprite selector. It sits between the VGA timing generator and the RGB565 output stage. It maps each pixel coordinate to a cell and picks one of four texture streams for that cell: LED-on, LED-off, default, or alternate. Black key pixels are replaced with the default texture. The ROM read latency is pipelined out, the LED status is latched once per frame so it cannot tear, and individually selected LEDs can blink.

## Interface
Parameters:
- COORD_W, 9: width of the pixel coordinates.
- CELL_BITS, 5: log2 of the cell edge. 5 gives 32x32 cells.
- N_LEDS, 13: number of LEDs in the LED row.
- LED_ROW, 3: cell row that holds the LEDs.
- LED_COL0, 1: cell column of the leftmost LED.
- ALT_LO, 2 and ALT_HI, 4: cell rows strictly below ALT_LO or strictly above ALT_HI use the alternate texture.
- ROM_LAT, 1: read latency of the external texture ROMs, in clocks, range 1..4.
- BLINK_FRAMES, 30: number of frames per blink half-period, at least 1.
- KEY_COLOR, 16'h0000: RGB565 value treated as transparent.

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: reset. Synchronous, active-high.
- i_x, i_y, in, COORD_W: pixel coordinates.
- i_de, in, 1: pixel valid (display enable).
- i_frame, in, 1: one-cycle pulse at the start of vertical blank.
- i_status, in, N_LEDS: requested LED state, 1 = on.
- i_blink, in, N_LEDS: blink enable per LED.
- o_rom_addr, out, 2*CELL_BITS: shared ROM address, {i_y[CELL_BITS-1:0], i_x[CELL_BITS-1:0]}.
- i_tex_on, i_tex_off, i_tex0, i_tex1, in, 16 each: ROM data in RGB565.
- o_r, out, 5; o_g, out, 6; o_b, out, 5: pixel colour.
- o_de, out, 1: output pixel valid.

## Operation
- Cell coordinates are cx = i_x[COORD_W-1:CELL_BITS] and cy = i_y[COORD_W-1:CELL_BITS].
- o_rom_addr is combinational from i_x and i_y. The ROMs return data ROM_LAT clocks later.
- Frame latch: on i_frame, status_q <= i_status and blink_q <= i_blink.
- Blink counter: on i_frame, frame_cnt increments. When frame_cnt = BLINK_FRAMES-1 it wraps to 0 and `phase` toggles.
- Effective LED state: led_k = status_q[k] & ~(blink_q[k] & phase).
- Texture select, computed at stage 0 in priority order:
  - LED cell: cy == LED_ROW and LED_COL0 <= cx <= LED_COL0+N_LEDS-1. Set k = N_LEDS-1-(cx-LED_COL0), so the leftmost LED is the MSB. Select ON if led_k = 1, else OFF.
  - Alternate: cy < ALT_LO or cy > ALT_HI selects TEX1.
  - Otherwise select TEX0.
- The 2-bit select and i_de pass through a ROM_LAT-deep delay line so they line up with the ROM data.
- Key replacement: if the selected ROM word == KEY_COLOR, output i_tex0 for that pixel instead.
- When the delayed de = 0, the output colour is 0.
- The output stage is registered.
- Select is evaluated with status_q and phase as they stand when the pixel enters stage 0. Pixels already in the pipeline keep their select when i_frame fires.
- i_frame in the same cycle as i_rst: reset wins.
- i_frame while i_de = 1 is legal. The change applies from the next pixel entering stage 0.

## Timing
- Latency from i_x/i_y/i_de to o_r/o_g/o_b/o_de is ROM_LAT+1 clocks. Throughput is one pixel per clock.
- Values on reset: o_r, o_g, o_b and o_de are 0. status_q, blink_q, frame_cnt and phase are 0. All delay-line stages are 0.
- Outputs are valid from the first clock after reset deasserts; pipeline stages that have not yet been filled present de = 0.
- status_q and blink_q are updated on the clock edge where i_frame is sampled high. The first pixel to see the new values is the one presented in the following cycle.

## Structure
- Shared package tile_pkg holds:
  - texture select constants: SEL_TEX0=0, SEL_TEX1=1, SEL_ON=2, SEL_OFF=3;
  - RGB565 field positions: R [15:11], G [10:5], B [4:0];
  - the default KEY_COLOR.
- One sub-module, pipe_delay, a parametrised WIDTH x DEPTH shift register with synchronous reset. It is instantiated once for {sel, de}.
- ROMs are instantiated by the parent. This block only drives the address and muxes the data.

## Test plan
- Reset release, ROM_LAT=1, i_de=1 at (0,0) with i_tex1=16'hF800 → o_de=0 and colour 0 during reset; 2 clocks after the pixel, o_r=31, o_g=0, o_b=0, o_de=1.
- i_status=13'h1000, i_frame pulse, then a pixel at cell (1,3) with i_tex_on=16'h07E0 → output 16'h07E0. Pixel at cell (2,3) → output equals i_tex_off.
- Selected word = 16'h0000 and i_tex0=16'h001F → output 16'h001F. With KEY_COLOR=16'hFFFF, a 16'h0000 word passes through unchanged.
- BLINK_FRAMES=2, i_status=i_blink=13'h0001, cell (13,3) → reads ON for frames 0–1, OFF for frames 2–3, ON again for frame 4.
- i_status changes mid-frame with no i_frame → output unchanged until the next i_frame. i_frame asserted together with i_rst → status_q stays 0.
- ROM_LAT=3, CELL_BITS=4, pixel at (16,48), i.e. cell (1,3) → o_rom_addr=8'h00, output after 4 clocks, select equals ON/OFF per the latched status.
